// File: rtl/fp_add_arb_if.sv
// Requester-side and adder-side signals of the round-robin FP add arbiter.
// The slave modport is the arbiter; master is whoever drives requests and models the adder.
interface fp_add_arb_if #(
    parameter int N   = 4,
    parameter int MSB = 31
);
    logic                     enable;
    logic [N-1:0]             req;
    logic [N*(MSB+1)-1:0]     opa;
    logic [N*(MSB+1)-1:0]     opb;
    logic [N-1:0]             grant;
    logic                     done;
    logic [2:0]               rsp_id;
    logic [MSB:0]             rsp_data;
    logic                     rsp_err;
    logic                     fp_req;
    logic [MSB:0]             fp_rx_data_1;
    logic [MSB:0]             fp_rx_data_2;
    logic                     fp_enable;
    logic                     fp_ack;
    logic [MSB:0]             fp_tx_data;

    modport slave (
        input  enable, req, opa, opb, fp_ack, fp_tx_data,
        output grant, done, rsp_id, rsp_data, rsp_err,
               fp_req, fp_rx_data_1, fp_rx_data_2, fp_enable
    );

    modport master (
        output enable, req, opa, opb, fp_ack, fp_tx_data,
        input  grant, done, rsp_id, rsp_data, rsp_err,
               fp_req, fp_rx_data_1, fp_rx_data_2, fp_enable
    );
endinterface

// File: rtl/fp_add_arb.sv
// Round-robin arbiter sharing one toggle-handshake FP adder among N requesters,
// with a watchdog that aborts a stuck adder and pulses it with fp_enable low.
module fp_add_arb #(
    parameter int N   = 4,
    parameter int MSB = 31,
    parameter int TMO = 63
) (
    input  logic        clk,
    input  logic        rstn,
    fp_add_arb_if.slave bus
);
    localparam int          W       = MSB + 1;
    localparam int          PW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0] NV      = (PW+1)'(N);
    localparam logic [7:0]  WD_LAST = 8'(TMO - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] ABORT     = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    logic [PW:0]   cand;
    logic [7:0]    wdog;

    // Search starts one past the last winner, so a held request yields to all others.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= NV) cand = cand - NV;
            if (!found && bus.req[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= IDLE;
            ptr              <= PW'(N - 1);
            wdog             <= '0;
            bus.grant        <= '0;
            bus.done         <= 1'b0;
            bus.rsp_id       <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_err      <= 1'b0;
            bus.fp_req       <= 1'b0;
            bus.fp_rx_data_1 <= '0;
            bus.fp_rx_data_2 <= '0;
            bus.fp_enable    <= 1'b0;
        end else begin
            bus.grant     <= '0;
            bus.done      <= 1'b0;
            bus.fp_enable <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.enable && bus.fp_ack && found) begin
                        bus.grant        <= N'(1) << win;
                        bus.rsp_id       <= 3'(win);
                        bus.fp_rx_data_1 <= bus.opa[int'(win)*W +: W];
                        bus.fp_rx_data_2 <= bus.opb[int'(win)*W +: W];
                        ptr              <= win;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.fp_req <= ~bus.fp_req;
                    wdog       <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    // A completing adder wins over a watchdog expiring on the same edge.
                    if (state == WAIT_DONE && bus.fp_ack) begin
                        bus.rsp_data <= bus.fp_tx_data;
                        bus.rsp_err  <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= IDLE;
                    end else if (wdog == WD_LAST) begin
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.done      <= 1'b1;
                        bus.fp_enable <= 1'b0;
                        wdog          <= '0;
                        state         <= ABORT;
                    end else begin
                        wdog <= wdog + 8'd1;
                        if (state == WAIT_BUSY && !bus.fp_ack) state <= WAIT_DONE;
                    end
                end
                ABORT: begin
                    if (wdog[0]) begin
                        state <= IDLE;
                    end else begin
                        bus.fp_enable <= 1'b0;
                        wdog          <= wdog + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_arb.sv
// Directed bench for fp_add_arb: a toggle-handshake FP adder model plus a
// grant/response scoreboard checked by an independent monitor.
module tb_fp_add_arb;
    localparam int N   = 4;
    localparam int MSB = 31;
    localparam int TMO = 63;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fp_add_arb_if #(.N(N), .MSB(MSB)) bus ();
    fp_add_arb #(.N(N), .MSB(MSB), .TMO(TMO)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic [3:0] gq[$];
    rsp_t       rq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int toggles = 0;
    logic last_fpreq = 1'b0;
    int last_g = 0;
    logic have_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Adder model: toggle on fp_req starts an add, fp_enable low returns it to idle.
    logic        st_ack = 1'b1;
    logic [31:0] st_tx = '0;
    logic        st_last = 1'b0;
    int          st_cnt = 0;
    int          busy = 0;
    logic        hang = 1'b0;
    assign bus.fp_ack     = st_ack;
    assign bus.fp_tx_data = st_tx;

    always @(posedge clk) begin
        if (!bus.fp_enable) begin
            st_ack  <= 1'b1;
            st_cnt  <= 0;
            st_last <= bus.fp_req;
        end else if (bus.fp_req != st_last) begin
            st_last <= bus.fp_req;
            st_ack  <= 1'b0;
            st_cnt  <= busy;
        end else if (!st_ack && !hang) begin
            if (st_cnt == 0) begin
                st_ack <= 1'b1;
                st_tx  <= r2f(f2r(bus.fp_rx_data_1) + f2r(bus.fp_rx_data_2));
            end else begin
                st_cnt <= st_cnt - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    endtask

    // Monitor: every grant and done must match the next queued expectation.
    initial begin
        rsp_t e;
        logic [3:0] eg;
        forever begin
            @(negedge clk);
            if (bus.fp_req !== last_fpreq) begin
                toggles++;
                last_fpreq = bus.fp_req;
            end
            if (bus.grant !== 4'b0000) begin
                if (gq.size() == 0) fail("unexpected_grant", int'(bus.grant), 0);
                else begin
                    eg = gq.pop_front();
                    chk("grant", 64'(bus.grant), 64'(eg));
                end
                chk("grant_not_with_done", 64'(bus.done), 64'(0));
                if (have_last) chk("grant_spacing_ge4", 64'((cyc - last_g) >= 4), 64'(1));
                last_g    = cyc;
                have_last = 1'b1;
            end
            if (bus.done === 1'b1) begin
                if (rq.size() == 0) fail("unexpected_done", int'(bus.rsp_id), -1);
                else begin
                    e = rq.pop_front();
                    chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                end
            end
        end
    end

    task automatic expect_op(input logic [3:0] g, input logic [2:0] id, input logic [31:0] d, input logic err);
        rsp_t r;
        r.id = id; r.data = d; r.err = err;
        gq.push_back(g);
        rq.push_back(r);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.opa[i*32 +: 32] = a;
        bus.opb[i*32 +: 32] = b;
    endtask

    task automatic wait_grants(input int n, input int budget, output int gcyc);
        int seen = 0;
        gcyc = 0;
        for (int t = 0; t < budget && seen < n; t++) begin
            @(negedge clk);
            if (bus.grant != 4'b0000) begin
                seen++;
                gcyc = cyc;
            end
        end
        if (seen < n) fail("grant_timeout", seen, n);
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        logic got = 1'b0;
        dcyc = 0;
        for (int t = 0; t < budget && !got; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got  = 1'b1;
                dcyc = cyc;
            end
        end
        if (!got) fail("done_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && (gq.size() != 0 || rq.size() != 0); t++) @(negedge clk);
        if (gq.size() != 0) fail("grants_missing", gq.size(), 0);
        if (rq.size() != 0) fail("responses_missing", rq.size(), 0);
        gq.delete();
        rq.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_grant"}, 64'(bus.grant), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(0));
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
        chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
        chk({tag, "_fp_req"}, 64'(bus.fp_req), 64'(0));
        chk({tag, "_fp_rx1"}, 64'(bus.fp_rx_data_1), 64'(0));
        chk({tag, "_fp_rx2"}, 64'(bus.fp_rx_data_2), 64'(0));
        chk({tag, "_fp_enable"}, 64'(bus.fp_enable), 64'(0));
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        bus.req = '0;
        @(negedge clk);
        rstn      = 1'b1;
        have_last = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int gc, dc, t0, ng;
        rstn       = 1'b0;
        bus.enable = 1'b1;
        bus.req    = '0;
        bus.opa    = '0;
        bus.opb    = '0;
        @(negedge clk);
        check_reset_vals("por");
        rstn = 1'b1;
        @(negedge clk);
        chk("fp_enable_after_reset", 64'(bus.fp_enable), 64'(1));

        // Single add 1.0 + 2.0
        busy = 0;
        set_op(0, 32'h3F800000, 32'h40000000);
        expect_op(4'b0001, 3'd0, 32'h40400000, 1'b0);
        t0 = toggles;
        bus.req = 4'b0001;
        wait_grants(1, 20, gc);
        bus.req = '0;
        wait_done(40, dc);
        chk("single_latency", 64'(dc - gc), 64'(4));
        drain(50);
        chk("single_toggles", 64'(toggles - t0), 64'(1));
        chk("fp_enable_normal", 64'(bus.fp_enable), 64'(1));

        // Round robin with all four requesting
        do_reset();
        busy = 2;
        set_op(1, 32'h3FC00000, 32'h40200000);
        set_op(2, 32'h3F000000, 32'h3E800000);
        set_op(3, 32'h41200000, 32'h40C00000);
        expect_op(4'b0001, 3'd0, 32'h40400000, 1'b0);
        expect_op(4'b0010, 3'd1, 32'h40800000, 1'b0);
        expect_op(4'b0100, 3'd2, 32'h3F400000, 1'b0);
        expect_op(4'b1000, 3'd3, 32'h41800000, 1'b0);
        expect_op(4'b0001, 3'd0, 32'h40400000, 1'b0);
        bus.req = 4'b1111;
        wait_grants(5, 200, gc);
        bus.req = '0;
        drain(60);

        // Fairness between requesters 0 and 2
        do_reset();
        busy = 1;
        expect_op(4'b0001, 3'd0, 32'h40400000, 1'b0);
        expect_op(4'b0100, 3'd2, 32'h3F400000, 1'b0);
        expect_op(4'b0001, 3'd0, 32'h40400000, 1'b0);
        expect_op(4'b0100, 3'd2, 32'h3F400000, 1'b0);
        bus.req = 4'b0101;
        wait_grants(4, 200, gc);
        bus.req = '0;
        drain(60);

        // Watchdog abort on a hung adder, then recovery
        do_reset();
        hang = 1'b1;
        expect_op(4'b0001, 3'd0, 32'h00000000, 1'b1);
        bus.req = 4'b0001;
        wait_grants(1, 20, gc);
        bus.req = '0;
        wait_done(200, dc);
        chk("watchdog_latency", 64'(dc - gc), 64'(TMO + 1));
        chk("abort_fp_enable_c1", 64'(bus.fp_enable), 64'(0));
        @(negedge clk);
        chk("abort_fp_enable_c2", 64'(bus.fp_enable), 64'(0));
        @(negedge clk);
        chk("abort_fp_enable_c3", 64'(bus.fp_enable), 64'(1));
        hang = 1'b0;
        busy = 1;
        set_op(3, 32'hBF800000, 32'h40400000);
        expect_op(4'b1000, 3'd3, 32'h40000000, 1'b0);
        bus.req = 4'b1000;
        wait_grants(1, 20, gc);
        bus.req = '0;
        drain(60);

        // Enable gating
        do_reset();
        bus.enable = 1'b0;
        bus.req    = 4'b0010;
        ng = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.grant != 4'b0000) ng++;
        end
        chk("no_grant_when_disabled", 64'(ng), 64'(0));
        expect_op(4'b0010, 3'd1, 32'h40800000, 1'b0);
        busy = 3;
        bus.enable = 1'b1;
        @(negedge clk);
        chk("grant_after_enable", 64'(bus.grant), 64'(4'b0010));
        bus.req    = '0;
        bus.enable = 1'b0;
        wait_done(40, dc);
        drain(40);
        bus.enable = 1'b1;

        // Reset while waiting on a busy adder
        do_reset();
        busy = 20;
        set_op(1, 32'h41200000, 32'h40C00000);
        gq.push_back(4'b0001);
        bus.req = 4'b0011;
        wait_grants(1, 20, gc);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_vals("midop");
        busy = 0;
        expect_op(4'b0001, 3'd0, 32'h40400000, 1'b0);
        rstn      = 1'b1;
        have_last = 1'b0;
        wait_grants(1, 20, gc);
        bus.req = '0;
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_add_arb.md
FP_ADD_ARB -- requirements
Module: fp_add_arb

Interface
REQ-001 Parameter N, default 4: number of requesters, 2..8.
REQ-002 Parameter MSB, default 31: operand/result MSB.
REQ-003 Parameter TMO, default 63: watchdog limit in cycles, 8..255.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 enable  input  1  global enable; low blocks new grants only.
REQ-007 req  input  N  level request per requester.
REQ-008 opa, opb  input  N*(MSB+1)  flattened operands; requester i at bits [i*(MSB+1)+:MSB+1].
REQ-009 grant  output  N  one-hot, 1-cycle pulse; operands of that requester captured at that edge.
REQ-010 done  output  1  1-cycle pulse; response fields valid while high.
REQ-011 rsp_id  output  3  index of the requester that owns the response.
REQ-012 rsp_data  output  MSB+1  sum result.
REQ-013 rsp_err  output  1  watchdog abort flag, qualified by done.
REQ-014 fp_req  output  1  toggle request to the adder.
REQ-015 fp_rx_data_1, fp_rx_data_2  output  MSB+1  adder operands.
REQ-016 fp_enable  output  1  adder enable.
REQ-017 fp_ack  input  1  adder idle indication, high when idle.
REQ-018 fp_tx_data  input  MSB+1  adder result.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ABORT. All outputs are registered.
REQ-020 IDLE: when enable=1, fp_ack=1 and req!=0, the block selects a winner round-robin, searching from index ptr+1 modulo N; it latches that requester's operands into fp_rx_data_1/2 and its index into rsp_id, pulses grant[winner], sets ptr to the winner, and moves to ISSUE.
REQ-021 ISSUE: fp_req inverts once, then the FSM moves to WAIT_BUSY. fp_rx_data_1/2 hold stable from grant until the next grant.
REQ-022 WAIT_BUSY: fp_ack=0 moves the FSM to WAIT_DONE.
REQ-023 WAIT_DONE: fp_ack=1 captures fp_tx_data into rsp_data, sets rsp_err=0, pulses done, and moves to IDLE. Grant-to-done latency is 3 cycles plus the adder's busy time.
REQ-024 A watchdog counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE. On reaching TMO, the block moves to ABORT, sets rsp_data=0 and rsp_err=1, and pulses done.
REQ-025 ABORT: fp_enable=0 for exactly 2 cycles, then the FSM moves to IDLE. fp_enable=1 in every other state after reset.
REQ-026 A new grant is never issued in the cycle done pulses; minimum spacing between grants is 4 cycles.
REQ-027 A requester that drops req after its grant still receives its done. Deasserting req before a grant cancels that request silently.
REQ-028 enable=0 during an operation does not stop it; completion or abort proceeds normally.
REQ-029 A requester holding req high after its done is granted again only after all other asserted requesters have been served.
REQ-030 Bits of rsp_id above the width needed for N read 0.

Reset
REQ-031 On rstn=0 at a clock edge, the block SHALL: set the state to IDLE, ptr=N-1, grant=0, done=0, rsp_id=0, rsp_data=0, rsp_err=0, fp_req=0, fp_rx_data_1/2=0, fp_enable=0, and clear the watchdog.
REQ-032 Reset mid-operation abandons the operation with no done pulse. fp_enable rises on the first cycle after rstn returns high.

Verification
REQ-033 Single add: req=4'b0001, opa0=0x3F800000, opb0=0x40000000, real adder -> grant=4'b0001, one fp_req toggle, done with rsp_id=0, rsp_data=0x40400000, rsp_err=0.
REQ-034 Round robin: req=4'b1111 held from reset -> grants in order 0,1,2,3,0; each done carries the matching rsp_id.
REQ-035 Fairness: req=4'b0101 held -> grants alternate 0,2,0,2; requesters 1 and 3 never granted.
REQ-036 Watchdog: adder stub holds fp_ack=0 after the toggle -> done with rsp_err=1 and rsp_data=0, exactly TMO cycles after WAIT_BUSY entry; fp_enable low 2 cycles; next request then completes correctly.
REQ-037 Enable gating: enable=0 with req=4'b0010 -> no grant. enable rising -> grant=4'b0010 on the next edge. enable dropped mid-operation -> done still pulses.
REQ-038 Reset mid-op: rstn=0 for 1 cycle while in WAIT_DONE -> no done pulse; all outputs at their reset values; with req=4'b0001 held, the first grant after reset goes to requester 0.
